flash_bus_arb: RTL and testbench
================================

Name: flash_bus_arb

Overview:
- Shares the single SPI flash between two Wishbone read-only masters: CPU instruction fetch (ibus) and CPU data reads (dbus).
- Sits between the servant CPU buses and the FLASH_* pins.
- Arbitrates one request at a time and performs a complete flash READ (0x03) transaction: command, 24-bit address, 32-bit data.
- Returns the word with a single-cycle ack.

Parameters:
- ADDR_BASE, 24'h100000, flash byte offset added to every bus address (firmware image location).
- SCK_DIV, 0, SPI half-period minus one, in ck cycles; sck half-period = SCK_DIV+1 cycles.
- GAP_CYC, 2, minimum ck cycles spi_cs stays high between transactions (must be >= 1).

Ports:
- ck  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_adr  in  32  ibus word address (bits [1:0] ignored)
- i_cyc  in  1  ibus request
- i_rdt  out  32  ibus read data
- i_ack  out  1  ibus ack, one-cycle pulse
- d_adr  in  32  dbus address (bits [1:0] ignored)
- d_cyc  in  1  dbus read request (writes are not routed here)
- d_rdt  out  32  dbus read data
- d_ack  out  1  dbus ack, one-cycle pulse
- spi_cs  out  1  flash chip select, active low
- spi_sck  out  1  SPI clock, mode 0
- spi_mosi  out  1  SPI data to flash
- spi_miso  in  1  SPI data from flash
- busy  out  1  high while any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): spi_cs=1, spi_sck=0, spi_mosi=0, i_ack=d_ack=0, i_rdt=d_rdt=0, busy=0, state=IDLE, grant=none.
- Reset mid-transaction: same values immediately. No ack is issued. The flash sees cs rise, which aborts its read.
- States:
  - IDLE: when d_cyc or i_cyc is high, latch grant and address, go to CMD.
  - CMD: 8 bits.
  - ADDR: 24 bits.
  - DATA: 32 bits.
  - ACK: 1 cycle.
  - GAP: GAP_CYC cycles, then back to IDLE.
- Arbitration (macro off): fixed priority, dbus over ibus. Sampled only in IDLE; the grant holds until ACK.
- Flash address = (ADDR_BASE + {adr[23:2],2'b00}) mod 2^24. Bits [31:24] are ignored.
- SPI mode 0:
  - spi_cs falls on the cycle after the IDLE grant.
  - mosi is set up while sck is low; the flash samples on the sck rising edge.
  - miso is sampled on each sck rising edge.
  - Bits are sent MSB first: 8'h03, then the 24-bit address.
  - mosi = 0 during DATA.
- Each SPI bit lasts 2*(SCK_DIV+1) ck cycles.
- Data assembly: the 4 received bytes b0..b3 (in arrival order) form rdt = {b3,b2,b1,b0} (little-endian).
- ACK state:
  - spi_cs=1, spi_sck=0.
  - Granted rdt is updated and its ack is high for exactly one cycle, only if that master's cyc is still high.
  - The other master's rdt and ack are unchanged and held low.
- Latency: ack is high exactly 2+128*(SCK_DIV+1) cycles after the first IDLE cycle with the winning cyc high.
- Abort: if the granted cyc drops mid-transfer, the transfer completes on the wire, no ack is given, and rdt is not updated.
- Back-to-back: a request pending at the end of GAP is granted in the following IDLE cycle. IDLE lasts a minimum of 1 cycle.
- Simultaneous i_cyc/d_cyc: one is served, the other waits. Neither is dropped.
- Address counter and bit counter wrap without error (address 24'hFFFFFC + 4 → 0 is the flash's concern).

Optional Feature:
- Macro: FLASH_ARB_RR_EN
- Defined: round-robin arbitration. On a tie in IDLE, the master not served last wins. The last-served flag resets to dbus, so the first tie goes to ibus. A lone requester always wins.
- Undefined: fixed dbus-over-ibus priority as above. The last-served register is not built.

Test Plan:
- Single ibus read, SCK_DIV=0, i_adr=32'h0000_0010, flash model bytes at 24'h100010..13 = 13 37 BE EF:
  - mosi stream = 03 10 00 10.
  - i_rdt = 32'hEFBE3713.
  - i_ack pulses once at cycle 130; d_ack stays 0.
- Simultaneous i_cyc and d_cyc at cycle 0 (macro off):
  - dbus is served first.
  - ibus is granted immediately after GAP_CYC; both get the correct data.
  - Repeat twice: dbus wins every tie.
- Same tie twice with FLASH_ARB_RR_EN:
  - First tie goes to ibus, second tie goes to dbus.
- Abort: drop d_cyc during DATA.
  - No d_ack; d_rdt keeps its old value.
  - spi_cs rises at the normal time.
  - A following i_cyc is served correctly.
- Assert rst_n low mid-ADDR:
  - spi_cs=1 and sck=0 asynchronously.
  - busy=0 and no ack.
  - After release, a new request produces a clean 03 command.
- SCK_DIV=3, d_adr=32'h00FF_FFFC, ADDR_BASE=24'h100000:
  - Address sent = 24'h0FFFFC.
  - sck half-period = 4 cycles.
  - Ack at cycle 514.

Source files
------------

// File: rtl/flash_bus_arb.sv
// flash_bus_arb: shares one SPI flash between the servant ibus and dbus
// Wishbone read masters. Each granted request runs a full READ (0x03)
// transaction in SPI mode 0: 8-bit command, 24-bit address, 32-bit data.
// The word is returned with a one-cycle ack.
// Optional feature macro: FLASH_ARB_RR_EN. When it is defined, ties use
// round-robin arbitration. When it is undefined, dbus always wins a tie.
module flash_bus_arb #(
    parameter logic [23:0] ADDR_BASE = 24'h100000,
    parameter int unsigned SCK_DIV   = 0,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic [31:0] i_adr,
    input  logic        i_cyc,
    output logic [31:0] i_rdt,
    output logic        i_ack,
    input  logic [31:0] d_adr,
    input  logic        d_cyc,
    output logic [31:0] d_rdt,
    output logic        d_ack,
    output logic        spi_cs,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    localparam int unsigned DIV_W = (SCK_DIV > 0) ? $clog2(SCK_DIV + 1) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ACK,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    state_t             state;
    state_t             state_next;
    grant_t             grant;
    logic [31:0]        tx_sr;
    logic [31:0]        rx_sr;
    logic [31:0]        rx_word;
    logic [DIV_W-1:0]   div_cnt;
    logic               half;
    logic [5:0]         bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               half_end;
    logic               sck_rise;
    logic               bit_end;
    logic               req;
    logic               pick_d;
    logic [31:0]        sel_adr;
    logic [23:0]        flash_adr;
    logic               unused_adr_bits;

    assign unused_adr_bits = ^{i_adr[31:24], i_adr[1:0], d_adr[31:24], d_adr[1:0]};

    // Bytes arrive b0 first in rx_sr[31:24]; the bus word is little-endian.
    assign rx_word = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};

`ifdef FLASH_ARB_RR_EN
    logic last_d;

    // Remember which master was granted last so the next tie goes to the other.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (state == S_IDLE && req) begin
            last_d <= pick_d;
        end
    end

    // On a tie, grant the master that was not served last.
    always_comb begin
        pick_d = d_cyc && (!i_cyc || !last_d);
    end
`else
    // Fixed priority: dbus wins every tie.
    always_comb begin
        pick_d = d_cyc;
    end
`endif

    // Request detection and flash address of the winning master.
    always_comb begin
        req       = i_cyc || d_cyc;
        sel_adr   = pick_d ? d_adr : i_adr;
        flash_adr = ADDR_BASE + {sel_adr[23:2], 2'b00};
    end

    // State register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and SPI pin decode.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        spi_cs     = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        half_end   = (div_cnt == DIV_W'(SCK_DIV));
        sck_rise   = !half && half_end;
        bit_end    = half && half_end;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                spi_cs   = 1'b0;
                spi_sck  = half;
                spi_mosi = tx_sr[31];
                if (bit_end && bit_cnt == 6'd7) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                spi_cs   = 1'b0;
                spi_sck  = half;
                spi_mosi = tx_sr[31];
                if (bit_end && bit_cnt == 6'd31) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                spi_cs  = 1'b0;
                spi_sck = half;
                if (bit_end && bit_cnt == 6'd63) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: grant/address latch, SPI shifting, and bus responses.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= GNT_NONE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            div_cnt <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            i_rdt   <= '0;
            d_rdt   <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    half    <= 1'b0;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                    if (req) begin
                        grant <= pick_d ? GNT_D : GNT_I;
                        tx_sr <= {8'h03, flash_adr};
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        half    <= ~half;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (sck_rise && state == S_DATA) begin
                        rx_sr <= {rx_sr[30:0], spi_miso};
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                    end
                end
                S_ACK: begin
                    if (grant == GNT_D && d_cyc) begin
                        d_rdt <= rx_word;
                        d_ack <= 1'b1;
                    end
                    if (grant == GNT_I && i_cyc) begin
                        i_rdt <= rx_word;
                        i_ack <= 1'b1;
                    end
                    grant <= GNT_NONE;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_bus_arb.sv
// tb_flash_bus_arb: randomized self-checking bench for flash_bus_arb.
// It instantiates two copies of the arbiter, one with SCK_DIV=0 and one
// with SCK_DIV=3. Each copy talks to its own behavioural SPI flash model.
module tb_flash_bus_arb;

    localparam logic [23:0] BASE = 24'h100000;
    localparam int unsigned GAP  = 2;

    logic        ck = 1'b0;
    logic        rst_n;
    logic [31:0] i_adr_v [2];
    logic [31:0] d_adr_v [2];
    logic [31:0] i_rdt_v [2];
    logic [31:0] d_rdt_v [2];
    logic [1:0]  i_cyc_v, d_cyc_v, i_ack_v, d_ack_v;
    logic [1:0]  cs_v, sck_v, mosi_v, busy_v;
    bit          last_d [2];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 ck = ~ck;

    // Flash content: fixed test-plan bytes, otherwise a hash of the address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [7:0] h;
        case (a)
            24'h100010: return 8'h13;
            24'h100011: return 8'h37;
            24'h100012: return 8'hBE;
            24'h100013: return 8'hEF;
            default: begin
                h = a[7:0] * 8'd37;
                return h ^ a[15:8] ^ a[23:16] ^ 8'hA5;
            end
        endcase
    endfunction

    function automatic logic [23:0] flash_addr(input logic [31:0] adr);
        return BASE + {adr[23:2], 2'b00};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] adr);
        logic [23:0] a0, a1, a2, a3;
        a0 = flash_addr(adr);
        a1 = a0 + 24'd1;
        a2 = a0 + 24'd2;
        a3 = a0 + 24'd3;
        return {mem_byte(a3), mem_byte(a2), mem_byte(a1), mem_byte(a0)};
    endfunction

    function automatic int unsigned div_of(input int sel);
        return (sel != 0) ? 3 : 0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        logic        miso;
        int          cnt;
        logic [31:0] sh;
        int          rec_n;
        logic [7:0]  rec_cmd;
        logic [23:0] rec_adr;
        logic [23:0] ba;
        logic [7:0]  mb;

        flash_bus_arb #(
            .ADDR_BASE (BASE),
            .SCK_DIV   (g * 3),
            .GAP_CYC   (GAP)
        ) dut (
            .ck       (ck),
            .rst_n    (rst_n),
            .i_adr    (i_adr_v[g]),
            .i_cyc    (i_cyc_v[g]),
            .i_rdt    (i_rdt_v[g]),
            .i_ack    (i_ack_v[g]),
            .d_adr    (d_adr_v[g]),
            .d_cyc    (d_cyc_v[g]),
            .d_rdt    (d_rdt_v[g]),
            .d_ack    (d_ack_v[g]),
            .spi_cs   (cs_v[g]),
            .spi_sck  (sck_v[g]),
            .spi_mosi (mosi_v[g]),
            .spi_miso (miso),
            .busy     (busy_v[g])
        );

        initial begin
            miso = 1'b0;
            cnt  = 0;
            sh   = '0;
            rec_n = 0;
        end

        // Flash model: start of a transaction.
        always @(negedge cs_v[g]) begin
            cnt  = 0;
            sh   = '0;
            miso = 1'b0;
        end

        // Flash model: capture command and address on each rising sck edge.
        always @(posedge sck_v[g]) begin
            if (!cs_v[g]) begin
                if (cnt < 32) sh = {sh[30:0], mosi_v[g]};
                cnt = cnt + 1;
            end
        end

        // Flash model: present the next data bit after each falling sck edge.
        always @(negedge sck_v[g]) begin
            if (!cs_v[g] && cnt >= 32) begin
                ba   = sh[23:0] + 24'((cnt - 32) / 8);
                mb   = mem_byte(ba);
                miso = mb[7 - ((cnt - 32) % 8)];
            end
        end

        // Flash model: record what was seen when cs rises.
        always @(posedge cs_v[g]) begin
            rec_n   = cnt;
            rec_cmd = sh[31:24];
            rec_adr = sh[23:0];
            miso    = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rec_of(input int sel);
        if (sel == 0) return {gi[0].rec_n[31:0], gi[0].rec_cmd, gi[0].rec_adr};
        else          return {gi[1].rec_n[31:0], gi[1].rec_cmd, gi[1].rec_adr};
    endfunction

    task automatic check_rec(input int sel, input logic [31:0] adr);
        logic [63:0] r;
        r = rec_of(sel);
        check("flash_bits", r[63:32], 64);
        check("flash_cmd", r[31:24], 8'h03);
        check("flash_addr", r[23:0], flash_addr(adr));
    endtask

    task automatic wait_idle(input int sel);
        int unsigned n;
        n = 0;
        @(negedge ck);
        while (busy_v[sel] && n < 2000) begin
            @(negedge ck);
            n++;
        end
        if (busy_v[sel]) check("idle_timeout", 1, 0);
    endtask

    // One request or a tie; the model predicts the order and ack cycles.
    task automatic run_txn(input int sel, input bit wi, input bit wd,
                           input logic [31:0] ia, input logic [31:0] da);
        int unsigned lat, t, ni, nd, ti, td, t_rise, ei, ed;
        bit d_first;
        lat = 2 + 128 * (div_of(sel) + 1);
        wait_idle(sel);
        if (wi && wd) begin
`ifdef FLASH_ARB_RR_EN
            d_first = !last_d[sel];
`else
            d_first = 1'b1;
`endif
            last_d[sel] = !d_first;
        end else begin
            d_first = wd;
            last_d[sel] = wd;
        end
        ei = (wi && wd && d_first)  ? 2 * lat + GAP : lat;
        ed = (wi && wd && !d_first) ? 2 * lat + GAP : lat;
        i_adr_v[sel] = ia;
        d_adr_v[sel] = da;
        i_cyc_v[sel] = wi;
        d_cyc_v[sel] = wd;
        t = 0; ni = 0; nd = 0; ti = 0; td = 0; t_rise = 0;
        while (t < 3 * lat + 50 && (i_cyc_v[sel] || d_cyc_v[sel])) begin
            @(negedge ck);
            t++;
            if (t_rise == 0 && sck_v[sel]) t_rise = t;
            if (i_ack_v[sel]) begin
                ni++; ti = t;
                check("i_rdt", i_rdt_v[sel], exp_word(ia));
                check_rec(sel, ia);
                i_cyc_v[sel] = 1'b0;
            end
            if (d_ack_v[sel]) begin
                nd++; td = t;
                check("d_rdt", d_rdt_v[sel], exp_word(da));
                check_rec(sel, da);
                d_cyc_v[sel] = 1'b0;
            end
        end
        if (i_cyc_v[sel] || d_cyc_v[sel]) check("ack_timeout", 1, 0);
        i_cyc_v[sel] = 1'b0;
        d_cyc_v[sel] = 1'b0;
        @(negedge ck);
        check("ack_pulse", {i_ack_v[sel], d_ack_v[sel]}, 2'b00);
        check("sck_first_rise", t_rise, 2 + div_of(sel));
        check("i_ack_count", ni, wi ? 1 : 0);
        check("d_ack_count", nd, wd ? 1 : 0);
        if (wi) check("i_ack_cycle", ti, ei);
        if (wd) check("d_ack_cycle", td, ed);
    endtask

    // dbus read dropped during DATA: the wire transfer completes, with no ack.
    task automatic run_abort(input int sel, input logic [31:0] da);
        int unsigned t, nd, ni, t_cs, drop_t, dv;
        logic [31:0] old;
        dv = div_of(sel);
        wait_idle(sel);
        old = d_rdt_v[sel];
        last_d[sel] = 1'b1;
        d_adr_v[sel] = da;
        d_cyc_v[sel] = 1'b1;
        drop_t = 1 + 2 * (dv + 1) * 40;
        t = 0; nd = 0; ni = 0; t_cs = 0;
        while (t < 4 * (2 + 128 * (dv + 1))) begin
            @(negedge ck);
            t++;
            if (t == 1) check("cs_fall", cs_v[sel], 1'b0);
            if (t == drop_t) d_cyc_v[sel] = 1'b0;
            if (t > 1 && t_cs == 0 && cs_v[sel]) t_cs = t;
            if (d_ack_v[sel]) nd++;
            if (i_ack_v[sel]) ni++;
            if (t > drop_t && !busy_v[sel]) break;
        end
        check("abort_cs_rise", t_cs, 1 + 128 * (dv + 1));
        check("abort_d_ack", nd, 0);
        check("abort_i_ack", ni, 0);
        check("abort_d_rdt", d_rdt_v[sel], old);
        check("abort_idle", busy_v[sel], 1'b0);
    endtask

    // Reset asserted mid-ADDR on instance 0.
    task automatic run_reset_mid();
        int unsigned t;
        logic [63:0] r;
        wait_idle(0);
        d_adr_v[0] = $urandom;
        d_cyc_v[0] = 1'b1;
        t = 0;
        while (t < 1 + 2 * 16) begin
            @(negedge ck);
            t++;
        end
        check("pre_rst_cs", cs_v[0], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_cs", cs_v[0], 1'b1);
        check("rst_sck", sck_v[0], 1'b0);
        check("rst_mosi", mosi_v[0], 1'b0);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_ack", {i_ack_v[0], d_ack_v[0]}, 2'b00);
        r = rec_of(0);
        check("rst_flash_aborted", r[63:32] < 64, 1'b1);
        d_cyc_v[0] = 1'b0;
        last_d[0] = 1'b1;
        last_d[1] = 1'b1;
        @(negedge ck);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sel, kind;
        rst_n   = 1'b0;
        i_cyc_v = '0;
        d_cyc_v = '0;
        for (int i = 0; i < 2; i++) begin
            i_adr_v[i] = '0;
            d_adr_v[i] = '0;
            last_d[i]  = 1'b1;
        end
        @(negedge ck);
        check("reset_cs", cs_v, 2'b11);
        check("reset_sck", sck_v, 2'b00);
        check("reset_mosi", mosi_v, 2'b00);
        check("reset_busy", busy_v, 2'b00);
        check("reset_ack", {i_ack_v, d_ack_v}, 4'b0000);
        check("reset_rdt", {i_rdt_v[0], d_rdt_v[0], i_rdt_v[1], d_rdt_v[1]}, 128'h0);
        @(negedge ck);
        rst_n = 1'b1;

        // Single ibus read of the fixed flash bytes.
        run_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check("i_rdt_fixed", i_rdt_v[0], 32'hEFBE3713);

        // Two ties in a row.
        run_txn(0, 1'b1, 1'b1, $urandom, $urandom);
        run_txn(0, 1'b1, 1'b1, $urandom, $urandom);

        // Abort, then a normal ibus read.
        run_abort(0, $urandom);
        run_txn(0, 1'b1, 1'b0, $urandom, $urandom);

        // Reset mid-transaction, then a clean read.
        run_reset_mid();
        run_txn(0, 1'b0, 1'b1, $urandom, $urandom);

        // Slow SCK and address wrap: 0x100000 + 0xFFFFFC wraps to 0x0FFFFC.
        run_txn(1, 1'b0, 1'b1, 32'h0, 32'h00FF_FFFC);
        check("wrap_addr", rec_of(1) & 64'hFF_FFFF, 64'h0F_FFFC);
        run_txn(1, 1'b1, 1'b1, $urandom, $urandom);

        // Random mix of lone and tied requests on both instances.
        for (int n = 0; n < 14; n++) begin
            sel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            kind = $urandom_range(0, 2);
            run_txn(int'(sel), kind != 1, kind != 0, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
